line_bus_responder: RTL and testbench
=====================================

Name: line_bus_responder

Overview:
- Memory-side end of the cache line bus; it serves line fill (load) and line writeback (store) commands issued by the L1 cache controllers.
- Each line command is split into 2**OFFSET_LENGTH word beats on a narrow request/response memory port.
- Read beats are gathered into a full line. Completion is returned to the cache as a one-cycle bus_valid (load) or bus_ready (store) pulse.

Parameters:
OFFSET_LENGTH, 4, log2 of words per line; BEATS = 2**OFFSET_LENGTH
DATA_WIDTH, 64, word/beat width in bits
ADDR_WIDTH, 64, word-granular address width
TIMEOUT_CYCLES, 256, response watchdog limit (used only with LINE_RESP_TIMEOUT_EN)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
command_valid  input  1  cache command present; held until completion pulse
command_store  input  1  1 = line writeback
command_rready  input  1  1 = line fill (ignored when command_store=1)
command_addr  input  ADDR_WIDTH  line address; low OFFSET_LENGTH bits ignored
data_to_bus  input  DATA_WIDTH*BEATS  writeback line from cache
data_from_bus  output  DATA_WIDTH*BEATS  fill line to cache
bus_valid  output  1  fill complete pulse
bus_ready  output  1  writeback complete pulse
mem_req_valid  output  1  beat request valid
mem_req_ready  input  1  memory accepts beat request
mem_req_we  output  1  1 = write beat
mem_req_addr  output  ADDR_WIDTH  beat address
mem_req_wdata  output  DATA_WIDTH  write beat data
mem_resp_valid  input  1  read beat returned, in request order
mem_resp_rdata  input  DATA_WIDTH  read beat data
bus_err  output  1  timeout pulse; tied 0 without LINE_RESP_TIMEOUT_EN

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; data_from_bus=0; beat counters 0; latched address and line cleared.
- States: IDLE, RD, WR, DONE.
- IDLE, command_valid=1:
  - store=1: latch address and data_to_bus, go to WR.
  - store=0, rready=1: latch address, go to RD.
  - store=0, rready=0: ignored, stay IDLE.
- Beat packing: beat i uses bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]. Beat address = {latched_addr[ADDR_WIDTH-1:OFFSET_LENGTH], i}.
- Beat issue order: i = 0..BEATS-1.
- RD:
  - mem_req_valid=1, we=0 while issue count < BEATS; issue count advances on valid&&ready.
  - Multiple outstanding beats are allowed.
  - Each mem_resp_valid stores rdata into slot[resp count] and increments resp count.
  - Go to DONE in the cycle after the last response is captured.
  - mem_resp_valid when resp count == BEATS, or in IDLE, WR or DONE, is dropped.
- WR:
  - mem_req_valid=1, we=1, wdata = beat[issue count].
  - Go to DONE after the last beat handshake. No write response is expected.
- DONE:
  - Exactly one cycle: bus_valid=1 (read) or bus_ready=1 (write), then return to IDLE.
  - data_from_bus is stable from the DONE cycle until the next fill begins capturing.
- Back-to-back commands:
  - IDLE samples the cache command in the cycle after DONE, so a fill followed immediately by a writeback (command_valid held high, command_store flipped) is accepted as a new command.
  - A command is never served twice.
- Request hold: mem_req_valid, addr and wdata stay stable while mem_req_ready=0.
- Zero-wait latency: command seen in cycle 0; requests in cycles 1..BEATS.
  - Fill, with responses one cycle after requests: bus_valid in cycle BEATS+2.
  - Writeback: bus_ready in cycle BEATS+1.
- Reset mid-operation: the command is aborted with no pulse; in-flight responses after reset release are dropped.

Optional Feature:
- LINE_RESP_TIMEOUT_EN defined:
  - In RD, a watchdog counts cycles since the last request handshake or response.
  - On reaching TIMEOUT_CYCLES, go to DONE; bus_valid and bus_err pulse together; uncaptured slots read as 0.
  - The watchdog clears on entry to IDLE.
- Not defined: no watchdog; bus_err is constant 0; RD waits indefinitely.

Test Plan:
- OFFSET_LENGTH=2. Fill at addr 0x1234; mem always ready, responds with rdata=addr one cycle after each request -> mem_req_addr 0x1234,0x1235,0x1236,0x1237 in cycles 1-4; bus_valid only in cycle 6; data_from_bus = {0x1237,0x1236,0x1235,0x1234}.
- Writeback at addr 0x40 with line {D,C,B,A} -> write beats A@0x40, B@0x41, C@0x42, D@0x43; bus_ready single pulse in cycle 5; bus_valid stays 0.
- Fill with mem_req_ready toggling 1,0,1,0 and responses delayed 3 cycles -> request outputs stable while stalled; the line is still correct; exactly one bus_valid.
- Fill of 0x80 completes; command_valid held with store=1 in the following cycle -> write beats to 0x80-0x83 start; exactly one bus_valid then one bus_ready.
- reset=0 asserted after the 2nd read beat -> all outputs 0 immediately; late responses ignored; no completion pulse.
- With LINE_RESP_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never responds -> bus_valid and bus_err pulse together; data_from_bus = 0.

Source files
------------

// File: rtl/line_bus_responder_if.sv
// ---------------------------------------------------------------------------
// line_bus_responder_if
//
// Purpose: bundles the two bus sides that meet at the line bus responder.
//   - Cache side: a line command plus the full-line data in both directions,
//     and the completion/error pulses returned to the cache.
//   - Memory side: a word-wide request channel with valid/ready and an
//     in-order read response channel.
//
// Modports:
//   slave  - the responder's view (receives commands, drives memory beats)
//   master - the environment's view (cache controller and memory together)
//
// Parameters:
//   OFFSET_LENGTH - log2 of words per line
//   DATA_WIDTH    - word/beat width in bits
//   ADDR_WIDTH    - word-granular address width
// ---------------------------------------------------------------------------
interface line_bus_responder_if #(
  parameter int OFFSET_LENGTH = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 64
);

  localparam int BEATS      = 2 ** OFFSET_LENGTH;
  localparam int LINE_WIDTH = DATA_WIDTH * BEATS;

  // Cache-side line command and data
  logic                  command_valid;
  logic                  command_store;
  logic                  command_rready;
  logic [ADDR_WIDTH-1:0] command_addr;
  logic [LINE_WIDTH-1:0] data_to_bus;
  logic [LINE_WIDTH-1:0] data_from_bus;
  logic                  bus_valid;
  logic                  bus_ready;
  logic                  bus_err;

  // Memory-side beat request/response
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_rdata;

  modport slave (
    input  command_valid, command_store, command_rready, command_addr,
           data_to_bus, mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output data_from_bus, bus_valid, bus_ready, bus_err,
           mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );

  modport master (
    output command_valid, command_store, command_rready, command_addr,
           data_to_bus, mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  data_from_bus, bus_valid, bus_ready, bus_err,
           mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );

endinterface

// File: rtl/line_bus_responder.sv
// ---------------------------------------------------------------------------
// line_bus_responder
//
// Purpose: memory-side end of the cache line bus. A line fill (load) or line
// writeback (store) from an L1 controller is split into 2**OFFSET_LENGTH
// word beats on a narrow memory port. Read beats are gathered back into a
// full line; completion is a one-cycle bus_valid (fill) or bus_ready
// (writeback) pulse.
//
// Ports:
//   clk   - clock
//   reset - asynchronous, active-low reset
//   bus   - line_bus_responder_if.slave: cache command/data, completion
//           pulses, memory beat request and read response channels
//
// Optional feature (compile-time macro LINE_RESP_TIMEOUT_EN):
//   defined     - a response watchdog in the read state ends a stuck fill
//                 after TIMEOUT_CYCLES idle cycles, pulsing bus_valid
//                 together with bus_err; uncaptured words read as 0.
//   not defined - no watchdog, bus_err is constant 0, fills wait forever.
// ---------------------------------------------------------------------------
module line_bus_responder #(
  parameter int OFFSET_LENGTH  = 4,
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                 clk,
  input logic                 reset,
  line_bus_responder_if.slave bus
);

  localparam int BEATS      = 2 ** OFFSET_LENGTH;
  localparam int LINE_WIDTH = DATA_WIDTH * BEATS;
  localparam int CNT_W      = OFFSET_LENGTH + 1;
  localparam int LADDR_W    = ADDR_WIDTH - OFFSET_LENGTH;
  localparam int WD_W       = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] BEATS_CNT = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BEATS - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT_CYCLES - 1);

`ifdef LINE_RESP_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_e;

  state_e                state_q,     state_d;
  logic [LADDR_W-1:0]    line_addr_q, line_addr_d;
  logic [LINE_WIDTH-1:0] wr_line_q,   wr_line_d;
  logic [LINE_WIDTH-1:0] rd_line_q,   rd_line_d;
  logic [CNT_W-1:0]      issue_q,     issue_d;
  logic [CNT_W-1:0]      resp_q,      resp_d;
  logic                  is_rd_q,     is_rd_d;
  logic                  err_q,       err_d;
  logic [WD_W-1:0]       wd_q,        wd_d;

  logic req_valid;
  logic req_fire;
  logic resp_take;
  logic timeout_hit;
  logic unused_addr_bits;

  // The word offset of the command address is replaced by the beat index.
  assign unused_addr_bits = ^bus.command_addr[OFFSET_LENGTH-1:0];

  // Requests are driven purely from registered state, so address, data and
  // valid cannot move while memory holds ready low.
  assign req_valid = ((state_q == RD) || (state_q == WR)) && (issue_q < BEATS_CNT);
  assign req_fire  = req_valid && bus.mem_req_ready;

  // Responses only count in the read state and only until the line is full;
  // anything else arriving on the response channel is discarded.
  assign resp_take = (state_q == RD) && bus.mem_resp_valid && (resp_q < BEATS_CNT);

  // Watchdog: counts idle cycles in RD, restarting on every request
  // handshake or captured response. It is held at zero outside RD, which
  // also clears it on the way back to IDLE. With the feature disabled the
  // limit is never reported, so the counter has no effect.
  always_comb begin
    wd_d        = wd_q;
    timeout_hit = 1'b0;
    if (state_q != RD) begin
      wd_d = '0;
    end else if (req_fire || resp_take) begin
      wd_d = '0;
    end else if (WD_EN && (wd_q == WD_LIMIT)) begin
      timeout_hit = 1'b1;
      wd_d        = '0;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  // Next-state logic. A command is only sampled in IDLE, and IDLE always
  // follows DONE, so a held command_valid with a new command type is served
  // as a fresh command while the finished one is never served again.
  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    wr_line_d   = wr_line_q;
    rd_line_d   = rd_line_q;
    issue_d     = issue_q;
    resp_d      = resp_q;
    is_rd_d     = is_rd_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        issue_d = '0;
        resp_d  = '0;
        err_d   = 1'b0;
        if (bus.command_valid) begin
          if (bus.command_store) begin
            line_addr_d = bus.command_addr[ADDR_WIDTH-1:OFFSET_LENGTH];
            wr_line_d   = bus.data_to_bus;
            is_rd_d     = 1'b0;
            state_d     = WR;
          end else if (bus.command_rready) begin
            line_addr_d = bus.command_addr[ADDR_WIDTH-1:OFFSET_LENGTH];
            // Cleared up front so that words never returned read as 0.
            rd_line_d   = '0;
            is_rd_d     = 1'b1;
            state_d     = RD;
          end
        end
      end

      RD: begin
        if (req_fire) begin
          issue_d = issue_q + CNT_W'(1);
        end
        // Responses come back in request order, so the response count is
        // the slot index.
        if (resp_take) begin
          rd_line_d[int'(resp_q[OFFSET_LENGTH-1:0]) * DATA_WIDTH +: DATA_WIDTH] = bus.mem_resp_rdata;
          resp_d = resp_q + CNT_W'(1);
          if (resp_q == LAST_CNT) begin
            state_d = DONE;
          end
        end
        if (timeout_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end

      WR: begin
        // Writes have no response; the last accepted beat ends the command.
        if (req_fire) begin
          issue_d = issue_q + CNT_W'(1);
          if (issue_q == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset aborts any command in flight without a pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      wr_line_q   <= '0;
      rd_line_q   <= '0;
      issue_q     <= '0;
      resp_q      <= '0;
      is_rd_q     <= 1'b0;
      err_q       <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      wr_line_q   <= wr_line_d;
      rd_line_q   <= rd_line_d;
      issue_q     <= issue_d;
      resp_q      <= resp_d;
      is_rd_q     <= is_rd_d;
      err_q       <= err_d;
      wd_q        <= wd_d;
    end
  end

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_we    = (state_q == WR);
  assign bus.mem_req_addr  = {line_addr_q, issue_q[OFFSET_LENGTH-1:0]};
  assign bus.mem_req_wdata = (state_q == WR) ?
                             wr_line_q[int'(issue_q[OFFSET_LENGTH-1:0]) * DATA_WIDTH +: DATA_WIDTH] :
                             '0;

  // The fill line is only rewritten while RD is capturing, so it holds from
  // DONE until the next fill is accepted.
  assign bus.data_from_bus = rd_line_q;
  assign bus.bus_valid     = (state_q == DONE) && is_rd_q;
  assign bus.bus_ready     = (state_q == DONE) && !is_rd_q;
  assign bus.bus_err       = WD_EN && (state_q == DONE) && err_q;

endmodule

// File: tb/tb_line_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_line_bus_responder
//
// Drives line_bus_responder with OFFSET_LENGTH=2 (four 64-bit beats) from a
// table of fill/writeback commands, then a few hand-written multi-cycle
// sequences: back-to-back fill and writeback, an ignored command, reset in
// the middle of a fill, and (when LINE_RESP_TIMEOUT_EN is defined) the
// response watchdog. A small memory model answers read beats with
// rdata = beat address after a configurable delay.
// ---------------------------------------------------------------------------
module tb_line_bus_responder;

  localparam int OL    = 2;
  localparam int DW    = 64;
  localparam int AW    = 64;
  localparam int BEATS = 4;
  localparam int LW    = DW * BEATS;
  localparam int TO    = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  line_bus_responder_if #(.OFFSET_LENGTH(OL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  line_bus_responder #(
    .OFFSET_LENGTH (OL),
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit            store;
    logic [AW-1:0] addr;
    logic [LW-1:0] wline;
    int            ready_mode;
    int            resp_delay;
    int            exp_lat;
    logic [AW-1:0] exp_base;
    logic [LW-1:0] exp_line;
  } vec_t;

  vec_t vecs[5];

  int errors = 0;
  int checks = 0;

  // Memory model and monitor state
  int            cyc        = 0;
  int            cmd_cyc    = 0;
  int            ready_mode = 0;
  int            resp_delay = 1;
  bit            resp_en    = 1'b1;
  logic [AW-1:0] pend_addr[$];
  int            pend_due[$];
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  bit            log_we[$];
  int            nvalid = 0, nready = 0, nerr = 0;
  int            valid_cyc = 0, ready_cyc = 0, err_cyc = 0;
  int            hold_err = 0;
  bit            prev_stall = 1'b0;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  bit            st_we;

  // Snapshot of monitor counters at the start of a sequence
  int base_valid, base_ready, base_err, base_log, base_hold;

  // Memory model: runs mid-cycle, drives ready/response for the current
  // cycle, logs accepted beats, checks request hold while stalled and
  // records completion pulses with their cycle number.
  always @(negedge clk) begin
    cyc = cyc + 1;
    bus.mem_req_ready = (ready_mode == 0) ? 1'b1 : (((cyc - cmd_cyc) % 2) == 1);

    if (prev_stall) begin
      if (!bus.mem_req_valid || bus.mem_req_addr !== st_addr ||
          bus.mem_req_we !== st_we || bus.mem_req_wdata !== st_data)
        hold_err = hold_err + 1;
    end
    prev_stall = bus.mem_req_valid && !bus.mem_req_ready;
    st_addr    = bus.mem_req_addr;
    st_data    = bus.mem_req_wdata;
    st_we      = bus.mem_req_we;

    if (bus.mem_req_valid && bus.mem_req_ready && reset === 1'b1) begin
      log_addr.push_back(bus.mem_req_addr);
      log_data.push_back(bus.mem_req_wdata);
      log_we.push_back(bus.mem_req_we);
      if (!bus.mem_req_we) begin
        pend_addr.push_back(bus.mem_req_addr);
        pend_due.push_back(cyc + resp_delay);
      end
    end

    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    if (resp_en && pend_due.size() > 0) begin
      if (pend_due[0] <= cyc) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = pend_addr[0];
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
    end

    if (bus.bus_valid) begin nvalid = nvalid + 1; valid_cyc = cyc; end
    if (bus.bus_ready) begin nready = nready + 1; ready_cyc = cyc; end
    if (bus.bus_err)   begin nerr   = nerr + 1;   err_cyc   = cyc; end
  end

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic snapshot();
    base_valid = nvalid;
    base_ready = nready;
    base_err   = nerr;
    base_log   = log_addr.size();
    base_hold  = hold_err;
  endtask

  // Bounded wait for the total pulse count to reach target.
  task automatic waitEvents(input int target, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (nvalid + nready + nerr >= target) seen = 1'b1;
    end
    checks = checks + 1;
    if (!seen) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got no completion pulse in 80 cycles, required one", name);
    end
  endtask

  // Issues one table command, holds it until its completion pulse, then
  // drops it and lets a few quiet cycles pass so stray pulses are counted.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    #1;
    snapshot();
    cmd_cyc            = cyc;
    ready_mode         = v.ready_mode;
    resp_delay         = v.resp_delay;
    bus.command_valid  = 1'b1;
    bus.command_store  = v.store;
    bus.command_rready = 1'b1;
    bus.command_addr   = v.addr;
    bus.data_to_bus    = v.wline;
    waitEvents(base_valid + base_ready + base_err + 1, "pulse_wait");
    bus.command_valid  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    logic [LW-1:0] last_fill;
    logic [LW-1:0] b2b_line;
    logic [LW-1:0] b2b_fill;

    bus.command_valid  = 1'b0;
    bus.command_store  = 1'b0;
    bus.command_rready = 1'b0;
    bus.command_addr   = '0;
    bus.data_to_bus    = '0;

    vecs[0] = '{store: 1'b0, addr: 64'h1234, wline: '0, ready_mode: 0, resp_delay: 1,
                exp_lat: 6, exp_base: 64'h1234,
                exp_line: {64'h1237, 64'h1236, 64'h1235, 64'h1234}};
    vecs[1] = '{store: 1'b1, addr: 64'h40,
                wline: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                        64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                ready_mode: 0, resp_delay: 1, exp_lat: 5, exp_base: 64'h40, exp_line: '0};
    vecs[2] = '{store: 1'b0, addr: 64'h2002, wline: '0, ready_mode: 1, resp_delay: 3,
                exp_lat: 11, exp_base: 64'h2000,
                exp_line: {64'h2003, 64'h2002, 64'h2001, 64'h2000}};
    vecs[3] = '{store: 1'b1, addr: 64'h1FF7,
                wline: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                ready_mode: 1, resp_delay: 1, exp_lat: 8, exp_base: 64'h1FF4, exp_line: '0};
    vecs[4] = '{store: 1'b0, addr: 64'hFFFF_FFFF_FFFF_FFFE, wline: '0, ready_mode: 0,
                resp_delay: 2, exp_lat: 7, exp_base: 64'hFFFF_FFFF_FFFF_FFFC,
                exp_line: {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE,
                           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFC}};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_req_valid", bus.mem_req_valid, 0);
    checkOutput("rst_req_addr",  bus.mem_req_addr, 0);
    checkOutput("rst_bus_valid", bus.bus_valid, 0);
    checkOutput("rst_bus_ready", bus.bus_ready, 0);
    checkOutput("rst_bus_err",   bus.bus_err, 0);
    checkOutput("rst_line",      bus.data_from_bus, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven fills and writebacks
    last_fill = '0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      $display("[TB] vector %0d done", i);
      if (vecs[i].store) begin
        checkOutput("wb_ready_cycle", ready_cyc - cmd_cyc, vecs[i].exp_lat);
        checkOutput("wb_line_kept", bus.data_from_bus, last_fill);
      end else begin
        checkOutput("fill_valid_cycle", valid_cyc - cmd_cyc, vecs[i].exp_lat);
        checkOutput("fill_line", bus.data_from_bus, vecs[i].exp_line);
        last_fill = vecs[i].exp_line;
      end
      checkOutput("valid_pulses", nvalid - base_valid, vecs[i].store ? 0 : 1);
      checkOutput("ready_pulses", nready - base_ready, vecs[i].store ? 1 : 0);
      checkOutput("beat_count", log_addr.size() - base_log, BEATS);
      checkOutput("req_hold", hold_err - base_hold, 0);
      if (log_addr.size() - base_log == BEATS) begin
        for (int b = 0; b < BEATS; b++) begin
          checkOutput("beat_addr", log_addr[base_log + b], vecs[i].exp_base + 64'(b));
          checkOutput("beat_we", log_we[base_log + b], vecs[i].store);
          if (vecs[i].store)
            checkOutput("beat_wdata", log_data[base_log + b], vecs[i].wline[b*DW +: DW]);
        end
      end
    end

    // Fill of 0x80 followed at once by a writeback with command_valid held
    b2b_line = {64'h0D0D, 64'h0C0C, 64'h0B0B, 64'h0A0A};
    b2b_fill = {64'h83, 64'h82, 64'h81, 64'h80};
    @(negedge clk);
    #1;
    snapshot();
    cmd_cyc            = cyc;
    ready_mode         = 0;
    resp_delay         = 1;
    bus.command_valid  = 1'b1;
    bus.command_store  = 1'b0;
    bus.command_rready = 1'b1;
    bus.command_addr   = 64'h80;
    waitEvents(base_valid + base_ready + base_err + 1, "b2b_fill_wait");
    bus.command_store  = 1'b1;
    bus.data_to_bus    = b2b_line;
    waitEvents(base_valid + base_ready + base_err + 2, "b2b_wb_wait");
    bus.command_valid  = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("b2b_valid_pulses", nvalid - base_valid, 1);
    checkOutput("b2b_ready_pulses", nready - base_ready, 1);
    checkOutput("b2b_valid_cycle", valid_cyc - cmd_cyc, 6);
    checkOutput("b2b_ready_cycle", ready_cyc - cmd_cyc, 12);
    checkOutput("b2b_fill_line", bus.data_from_bus, b2b_fill);
    checkOutput("b2b_beat_count", log_addr.size() - base_log, 8);
    if (log_addr.size() - base_log == 8) begin
      for (int b = 0; b < BEATS; b++) begin
        checkOutput("b2b_wr_addr", log_addr[base_log + 4 + b], 64'h80 + 64'(b));
        checkOutput("b2b_wr_we", log_we[base_log + 4 + b], 1);
        checkOutput("b2b_wr_data", log_data[base_log + 4 + b], b2b_line[b*DW +: DW]);
      end
    end

    // Command with neither store nor rready is ignored
    @(negedge clk);
    #1;
    snapshot();
    bus.command_valid  = 1'b1;
    bus.command_store  = 1'b0;
    bus.command_rready = 1'b0;
    bus.command_addr   = 64'h600;
    repeat (6) @(negedge clk);
    #1;
    checkOutput("ign_req_valid", bus.mem_req_valid, 0);
    bus.command_valid  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("ign_beats", log_addr.size() - base_log, 0);
    checkOutput("ign_pulses", (nvalid - base_valid) + (nready - base_ready), 0);

    // Reset after the second read beat; responses arrive after release
    @(negedge clk);
    #1;
    snapshot();
    cmd_cyc            = cyc;
    ready_mode         = 0;
    resp_delay         = 6;
    bus.command_valid  = 1'b1;
    bus.command_store  = 1'b0;
    bus.command_rready = 1'b1;
    bus.command_addr   = 64'h300;
    repeat (3) @(negedge clk);
    #1;
    reset             = 1'b0;
    bus.command_valid = 1'b0;
    #1;
    checkOutput("mid_rst_req_valid", bus.mem_req_valid, 0);
    checkOutput("mid_rst_req_we",    bus.mem_req_we, 0);
    checkOutput("mid_rst_req_addr",  bus.mem_req_addr, 0);
    checkOutput("mid_rst_req_wdata", bus.mem_req_wdata, 0);
    checkOutput("mid_rst_line",      bus.data_from_bus, 0);
    checkOutput("mid_rst_bus_valid", bus.bus_valid, 0);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checkOutput("post_rst_pulses", (nvalid - base_valid) + (nready - base_ready), 0);
    checkOutput("post_rst_line", bus.data_from_bus, 0);
    checkOutput("post_rst_req_valid", bus.mem_req_valid, 0);
    resp_delay = 1;

`ifdef LINE_RESP_TIMEOUT_EN
    // Memory never answers: watchdog ends the fill with bus_err
    @(negedge clk);
    #1;
    snapshot();
    resp_en            = 1'b0;
    cmd_cyc            = cyc;
    ready_mode         = 0;
    bus.command_valid  = 1'b1;
    bus.command_store  = 1'b0;
    bus.command_rready = 1'b1;
    bus.command_addr   = 64'h500;
    waitEvents(base_valid + base_ready + base_err + 1, "timeout_wait");
    bus.command_valid  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("to_valid_pulses", nvalid - base_valid, 1);
    checkOutput("to_err_pulses", nerr - base_err, 1);
    checkOutput("to_valid_cycle", valid_cyc - cmd_cyc, 13);
    checkOutput("to_err_cycle", err_cyc - cmd_cyc, 13);
    checkOutput("to_line", bus.data_from_bus, 0);
`else
    checkOutput("no_bus_err", nerr, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
